// File: rtl/ibex_cmp_pkg.sv
// ibex_cmp_pkg
// Shared definitions for the comparator arbiter slice:
//   - comparator opcodes (CMP_*)
//   - cmp_req_t : one request payload {operator, a, b}
//   - cmp_rsp_t : one response entry  {id, cmp, eq}
//   - blk_state_e : response-register occupancy (EMPTY / FULL)
package ibex_cmp_pkg;

  localparam logic [6:0] CMP_LT  = 7'h19;
  localparam logic [6:0] CMP_LTU = 7'h1A;
  localparam logic [6:0] CMP_GE  = 7'h1B;
  localparam logic [6:0] CMP_EQ  = 7'h1D;
  localparam logic [6:0] CMP_NE  = 7'h1E;

  typedef struct packed {
    logic [6:0]  operator;
    logic [31:0] a;
    logic [31:0] b;
  } cmp_req_t;

  typedef struct packed {
    logic id;
    logic cmp;
    logic eq;
  } cmp_rsp_t;

  typedef enum logic {
    BLK_EMPTY = 1'b0,
    BLK_FULL  = 1'b1
  } blk_state_e;

endpackage

// File: rtl/IbexComparator.sv
// IbexComparator
// Purely combinational comparator. Uses the externally formed difference
// a + ~b + 1 for the ordered comparisons.
// Ports:
//   operator     in  7   opcode (CMP_LT/LTU/GE/EQ/NE); unknown codes -> equality
//   a, b         in  32  operands
//   adder_result in  32  a - b, wrapped to 32 bits
//   cmp          out 1   comparison result for the opcode
//   eq           out 1   a == b
module IbexComparator
  import ibex_cmp_pkg::*;
(
  input  logic [6:0]  operator,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] adder_result,
  output logic        cmp,
  output logic        eq
);

  logic lt_signed_s;
  logic lt_unsigned_s;

  // Compare decode: with differing operand signs the difference sign is
  // meaningless, so the ordering follows directly from the operand MSBs.
  always_comb begin
    eq            = (a == b);
    lt_signed_s   = (a[31] != b[31]) ? a[31] : adder_result[31];
    lt_unsigned_s = (a[31] != b[31]) ? b[31] : adder_result[31];
    case (operator)
      CMP_LT:  cmp = lt_signed_s;
      CMP_LTU: cmp = lt_unsigned_s;
      CMP_GE:  cmp = !lt_signed_s;
      CMP_EQ:  cmp = eq;
      CMP_NE:  cmp = !eq;
      default: cmp = eq;
    endcase
  end

endmodule

// File: rtl/ibex_cmp_arbiter.sv
// ibex_cmp_arbiter
// Two requesters (port 0: branch resolution, port 1: slt/compare) share one
// comparator. A round-robin arbiter picks one request per cycle; the result
// is returned through a single registered, ID-tagged response slot.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   io_reqX_valid_i / io_reqX_ready_o  request handshake, port X
//   io_reqX_operator_i / _a_i / _b_i   request payload, port X
//   io_rsp_valid_o / io_rsp_ready_i    response handshake
//   io_rsp_id_o, io_rsp_cmp_o, io_rsp_eq_o  registered response fields
//   io_cnt0_o / io_cnt1_o              saturating per-port grant counters
module ibex_cmp_arbiter
  import ibex_cmp_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             io_req0_valid_i,
  output logic             io_req0_ready_o,
  input  logic [6:0]       io_req0_operator_i,
  input  logic [31:0]      io_req0_a_i,
  input  logic [31:0]      io_req0_b_i,
  input  logic             io_req1_valid_i,
  output logic             io_req1_ready_o,
  input  logic [6:0]       io_req1_operator_i,
  input  logic [31:0]      io_req1_a_i,
  input  logic [31:0]      io_req1_b_i,
  output logic             io_rsp_valid_o,
  input  logic             io_rsp_ready_i,
  output logic             io_rsp_id_o,
  output logic             io_rsp_cmp_o,
  output logic             io_rsp_eq_o,
  output logic [CNT_W-1:0] io_cnt0_o,
  output logic [CNT_W-1:0] io_cnt1_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  cmp_req_t         req0_s;
  cmp_req_t         req1_s;
  cmp_req_t         sel_req_s;
  cmp_rsp_t         rsp_r;
  cmp_rsp_t         rsp_next_s;
  blk_state_e       state_r;
  blk_state_e       state_next_s;
  logic             last_grant_r;
  logic             winner_s;
  logic             have_winner_s;
  logic             can_accept_s;
  logic             accept_s;
  logic [31:0]      adder_result_s;
  logic             cmp_s;
  logic             eq_s;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  assign req0_s = '{operator: io_req0_operator_i, a: io_req0_a_i, b: io_req0_b_i};
  assign req1_s = '{operator: io_req1_operator_i, a: io_req1_a_i, b: io_req1_b_i};

  // Round-robin pick: a lone requester wins; on a tie the port that was not
  // granted last time wins.
  always_comb begin
    have_winner_s = 1'b0;
    winner_s      = 1'b0;
    if (io_req0_valid_i && io_req1_valid_i) begin
      have_winner_s = 1'b1;
      winner_s      = !last_grant_r;
    end else if (io_req0_valid_i) begin
      have_winner_s = 1'b1;
      winner_s      = 1'b0;
    end else if (io_req1_valid_i) begin
      have_winner_s = 1'b1;
      winner_s      = 1'b1;
    end else begin
      have_winner_s = 1'b0;
      winner_s      = 1'b0;
    end
  end

  // Operand mux and shared subtractor (wraps at 32 bits, carry dropped).
  always_comb begin
    sel_req_s = req0_s;
    if (winner_s) begin
      sel_req_s = req1_s;
    end else begin
      sel_req_s = req0_s;
    end
    adder_result_s = sel_req_s.a + ~sel_req_s.b + 32'd1;
  end

  IbexComparator u_comparator (
    .operator     (sel_req_s.operator),
    .a            (sel_req_s.a),
    .b            (sel_req_s.b),
    .adder_result (adder_result_s),
    .cmp          (cmp_s),
    .eq           (eq_s)
  );

  // The slot can take a new entry when empty or when it drains this cycle.
  assign can_accept_s    = (state_r == BLK_EMPTY) || io_rsp_ready_i;
  assign accept_s        = can_accept_s && have_winner_s;
  assign io_req0_ready_o = can_accept_s && have_winner_s && !winner_s;
  assign io_req1_ready_o = can_accept_s && have_winner_s && winner_s;
  assign rsp_next_s      = '{id: winner_s, cmp: cmp_s, eq: eq_s};

  // Response-slot occupancy next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      BLK_EMPTY: begin
        if (accept_s) begin
          state_next_s = BLK_FULL;
        end else begin
          state_next_s = BLK_EMPTY;
        end
      end
      BLK_FULL: begin
        if (accept_s) begin
          state_next_s = BLK_FULL;
        end else if (io_rsp_ready_i) begin
          state_next_s = BLK_EMPTY;
        end else begin
          state_next_s = BLK_FULL;
        end
      end
      default: state_next_s = BLK_EMPTY;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= BLK_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Response payload, arbiter history and saturating grant counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_r        <= '0;
      last_grant_r <= 1'b1;
      cnt0_r       <= '0;
      cnt1_r       <= '0;
    end else if (accept_s) begin
      rsp_r        <= rsp_next_s;
      last_grant_r <= winner_s;
      if (!winner_s && (cnt0_r != CNT_MAX)) begin
        cnt0_r <= cnt0_r + CNT_ONE;
      end
      if (winner_s && (cnt1_r != CNT_MAX)) begin
        cnt1_r <= cnt1_r + CNT_ONE;
      end
    end
  end

  assign io_rsp_valid_o = (state_r == BLK_FULL);
  assign io_rsp_id_o    = rsp_r.id;
  assign io_rsp_cmp_o   = rsp_r.cmp;
  assign io_rsp_eq_o    = rsp_r.eq;
  assign io_cnt0_o      = cnt0_r;
  assign io_cnt1_o      = cnt1_r;

endmodule

// File: tb/tb_ibex_cmp_arbiter.sv
// Directed testbench for ibex_cmp_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are sampled 1-2 time units after that edge.
// A second instance with CNT_W=2 covers counter saturation.
module tb_ibex_cmp_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        v0, v1, rdy0, rdy1;
  logic [6:0]  op0, op1;
  logic [31:0] a0, a1, b0, b1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cmp, rsp_eq;
  logic [15:0] cnt0, cnt1;

  logic        v0_2, rdy0_2, rdy1_2, rsp_valid_2, rsp_id_2, rsp_cmp_2, rsp_eq_2;
  logic [1:0]  cnt0_2, cnt1_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ibex_cmp_arbiter #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .io_req0_valid_i(v0), .io_req0_ready_o(rdy0), .io_req0_operator_i(op0),
    .io_req0_a_i(a0), .io_req0_b_i(b0),
    .io_req1_valid_i(v1), .io_req1_ready_o(rdy1), .io_req1_operator_i(op1),
    .io_req1_a_i(a1), .io_req1_b_i(b1),
    .io_rsp_valid_o(rsp_valid), .io_rsp_ready_i(rsp_ready),
    .io_rsp_id_o(rsp_id), .io_rsp_cmp_o(rsp_cmp), .io_rsp_eq_o(rsp_eq),
    .io_cnt0_o(cnt0), .io_cnt1_o(cnt1)
  );

  ibex_cmp_arbiter #(.CNT_W(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_ni),
    .io_req0_valid_i(v0_2), .io_req0_ready_o(rdy0_2), .io_req0_operator_i(op0),
    .io_req0_a_i(a0), .io_req0_b_i(b0),
    .io_req1_valid_i(1'b0), .io_req1_ready_o(rdy1_2), .io_req1_operator_i(op1),
    .io_req1_a_i(a1), .io_req1_b_i(b1),
    .io_rsp_valid_o(rsp_valid_2), .io_rsp_ready_i(1'b1),
    .io_rsp_id_o(rsp_id_2), .io_rsp_cmp_o(rsp_cmp_2), .io_rsp_eq_o(rsp_eq_2),
    .io_cnt0_o(cnt0_2), .io_cnt1_o(cnt1_2)
  );

  task automatic idle_inputs();
    v0 = 1'b0; v1 = 1'b0; v0_2 = 1'b0; rsp_ready = 1'b0;
    op0 = 7'h00; op1 = 7'h00; a0 = 32'd0; a1 = 32'd0; b0 = 32'd0; b1 = 32'd0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id: got %0b want 0", rsp_id); end
    checks++; if (rsp_cmp !== 1'b0) begin errors++; $display("FAIL reset_cmp: got %0b want 0", rsp_cmp); end
    checks++; if (rsp_eq !== 1'b0) begin errors++; $display("FAIL reset_eq: got %0b want 0", rsp_eq); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL reset_cnt0: got %0d want 0", cnt0); end
    checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL reset_cnt1: got %0d want 0", cnt1); end
    checks++; if ({rdy0, rdy1} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {rdy0, rdy1}); end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    v0 = 1'b1; op0 = 7'h1E; a0 = 32'd5; b0 = 32'd3; rsp_ready = 1'b1;
    #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL single_ready0: got %0b want 1", rdy0); end
    checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL single_ready1: got %0b want 0", rdy1); end
    @(posedge clk); #1;
    v0 = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id: got %0b want 0", rsp_id); end
    checks++; if (rsp_cmp !== 1'b1) begin errors++; $display("FAIL single_cmp: got %0b want 1", rsp_cmp); end
    checks++; if (rsp_eq !== 1'b0) begin errors++; $display("FAIL single_eq: got %0b want 0", rsp_eq); end
    checks++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL single_cnt0: got %0d want 1", cnt0); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    @(posedge clk); #1;
    v0 = 1'b1; op0 = 7'h1D; a0 = 32'd7; b0 = 32'd7;
    v1 = 1'b1; op1 = 7'h1A; a1 = 32'd1; b1 = 32'd2;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic exp_id;
      exp_id = i[0];
      #1;
      checks++; if ({rdy0, rdy1} !== {!exp_id, exp_id}) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", i, {rdy0, rdy1}, {!exp_id, exp_id}); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %0b want 1", i, rsp_valid); end
      checks++; if (rsp_id !== exp_id) begin errors++; $display("FAIL rr_id[%0d]: got %0b want %0b", i, rsp_id, exp_id); end
      checks++; if (rsp_cmp !== 1'b1) begin errors++; $display("FAIL rr_cmp[%0d]: got %0b want 1", i, rsp_cmp); end
      checks++; if (rsp_eq !== !exp_id) begin errors++; $display("FAIL rr_eq[%0d]: got %0b want %0b", i, rsp_eq, !exp_id); end
    end
    v0 = 1'b0; v1 = 1'b0;
    checks++; if (cnt0 !== 16'd2) begin errors++; $display("FAIL rr_cnt0: got %0d want 2", cnt0); end
    checks++; if (cnt1 !== 16'd2) begin errors++; $display("FAIL rr_cnt1: got %0d want 2", cnt1); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    @(posedge clk); #1;
    v1 = 1'b1; op1 = 7'h19; a1 = 32'hFFFF_FFFF; b1 = 32'd1; rsp_ready = 1'b0;
    #1;
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL bp_first_ready1: got %0b want 1", rdy1); end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({rdy0, rdy1} !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 00", k, {rdy0, rdy1}); end
      checks++; if ({rsp_valid, rsp_id, rsp_cmp, rsp_eq} !== 4'b1110) begin errors++; $display("FAIL bp_hold[%0d]: got %b want 1110", k, {rsp_valid, rsp_id, rsp_cmp, rsp_eq}); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL bp_release_ready1: got %0b want 1", rdy1); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble: got %0b want 1", rsp_valid); end
    checks++; if (cnt1 !== 16'd2) begin errors++; $display("FAIL bp_cnt1: got %0d want 2", cnt1); end
    op1 = 7'h1B; a1 = 32'd3; b1 = 32'd9;
    #1;
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL bp_pass_ready1: got %0b want 1", rdy1); end
    @(posedge clk); #1;
    v1 = 1'b0;
    checks++; if ({rsp_valid, rsp_id, rsp_cmp, rsp_eq} !== 4'b1100) begin errors++; $display("FAIL bp_replace: got %b want 1100", {rsp_valid, rsp_id, rsp_cmp, rsp_eq}); end
    checks++; if (cnt1 !== 16'd3) begin errors++; $display("FAIL bp_cnt1_final: got %0d want 3", cnt1); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b want 0", rsp_valid); end
  endtask

  task automatic test_wrap();
    v0 = 1'b1; op0 = 7'h1A; a0 = 32'h0000_0000; b0 = 32'hFFFF_FFFF; rsp_ready = 1'b1;
    #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL wrap_ready0: got %0b want 1", rdy0); end
    checks++; if (dut.adder_result_s !== 32'd1) begin errors++; $display("FAIL wrap_adder: got %h want 00000001", dut.adder_result_s); end
    @(posedge clk); #1;
    checks++; if ({rsp_valid, rsp_id, rsp_cmp, rsp_eq} !== 4'b1010) begin errors++; $display("FAIL wrap_ltu: got %b want 1010", {rsp_valid, rsp_id, rsp_cmp, rsp_eq}); end
    op0 = 7'h19;
    @(posedge clk); #1;
    v0 = 1'b0;
    checks++; if ({rsp_valid, rsp_id, rsp_cmp, rsp_eq} !== 4'b1000) begin errors++; $display("FAIL wrap_lt_signed: got %b want 1000", {rsp_valid, rsp_id, rsp_cmp, rsp_eq}); end
  endtask

  task automatic test_saturation();
    apply_reset();
    @(posedge clk); #1;
    v0_2 = 1'b1; op0 = 7'h1D; a0 = 32'd1; b0 = 32'd1;
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_cnt;
      exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
      @(posedge clk); #1;
      checks++; if (cnt0_2 !== exp_cnt) begin errors++; $display("FAIL sat_cnt0[%0d]: got %0d want %0d", i, cnt0_2, exp_cnt); end
      checks++; if (rsp_valid_2 !== 1'b1) begin errors++; $display("FAIL sat_valid[%0d]: got %0b want 1", i, rsp_valid_2); end
    end
    v0_2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(posedge clk); #1;
    v1 = 1'b1; op1 = 7'h1D; a1 = 32'd4; b1 = 32'd4; rsp_ready = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    v0 = 1'b1; op0 = 7'h19; a0 = 32'hFFFF_FFFB; b0 = 32'd2;
    @(posedge clk); #1;
    v0 = 1'b0;
    checks++; if ({rsp_valid, rsp_id, rsp_cmp, rsp_eq} !== 4'b1010) begin errors++; $display("FAIL mid_before: got %b want 1010", {rsp_valid, rsp_id, rsp_cmp, rsp_eq}); end
    checks++; if ({cnt0, cnt1} !== {16'd1, 16'd1}) begin errors++; $display("FAIL mid_before_cnt: got %0d/%0d want 1/1", cnt0, cnt1); end
    #1 rst_ni = 1'b0;
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_cmp, rsp_eq} !== 4'b0000) begin errors++; $display("FAIL mid_async_rsp: got %b want 0000", {rsp_valid, rsp_id, rsp_cmp, rsp_eq}); end
    checks++; if ({cnt0, cnt1} !== 32'd0) begin errors++; $display("FAIL mid_async_cnt: got %0d/%0d want 0/0", cnt0, cnt1); end
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    v0 = 1'b1; op0 = 7'h1D; a0 = 32'd2; b0 = 32'd2;
    v1 = 1'b1; op1 = 7'h1D; a1 = 32'd2; b1 = 32'd3;
    #1;
    checks++; if ({rdy0, rdy1} !== 2'b10) begin errors++; $display("FAIL mid_tie_ready: got %b want 10", {rdy0, rdy1}); end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    checks++; if ({rsp_valid, rsp_id, rsp_cmp, rsp_eq} !== 4'b1011) begin errors++; $display("FAIL mid_tie_rsp: got %b want 1011", {rsp_valid, rsp_id, rsp_cmp, rsp_eq}); end
    checks++; if ({cnt0, cnt1} !== {16'd1, 16'd0}) begin errors++; $display("FAIL mid_tie_cnt: got %0d/%0d want 1/0", cnt0, cnt1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_cmp_arbiter.md
# ibex_cmp_arbiter

Shares a single comparator datapath between two requesters: the branch-resolution path (port 0) and the set-less-than/compare path (port 1). Each requester uses a valid/ready handshake. A round-robin arbiter grants one request per cycle. The block forms the subtraction result, drives the existing comparator block, and returns a registered, ID-tagged response on a shared response channel. Per-port saturating grant counters provide performance visibility.

## Interface
- CNT_W, 16, width of each per-port grant counter
- clk_i  input  1  clock, all state updates on rising edge
- rst_ni  input  1  asynchronous, active-low reset
- io_req0_valid_i / io_req1_valid_i  input  1  request present on port 0 / port 1
- io_req0_ready_o / io_req1_ready_o  output  1  request accepted this cycle when high together with valid
- io_req0_operator_i / io_req1_operator_i  input  7  comparator opcode: 7'h19 LT, 7'h1A LTU, 7'h1B GE, 7'h1D EQ, 7'h1E NE
- io_req0_a_i / io_req1_a_i  input  32  operand a
- io_req0_b_i / io_req1_b_i  input  32  operand b
- io_rsp_valid_o  output  1  response register occupied
- io_rsp_ready_i  input  1  consumer accepts the response
- io_rsp_id_o  output  1  source port of the response
- io_rsp_cmp_o  output  1  comparison result
- io_rsp_eq_o  output  1  equality result (operand a == operand b)
- io_cnt0_o / io_cnt1_o  output  CNT_W  grants issued to each port, saturating

## Operation
- Operand difference: adder_result = a + ~b + 1, computed as 32-bit two's complement with wrap and the carry discarded. Only the winning request's operator, operands and adder_result go to the comparator.
- Arbitration: the rr_ptr register records the port that loses a tie next time. With exactly one port valid, that port wins. With both ports valid, the port other than last_grant wins. last_grant resets to 1, so port 0 wins the first tie.
- Capacity: can_accept = !rsp_valid || io_rsp_ready_i. io_reqX_ready_o = can_accept && (port X is the winner). The non-winning port sees ready low.
- Accept, meaning can_accept is high and a winner exists:
  - load the response register with {id, cmp, eq};
  - set rsp_valid;
  - set last_grant to the winner;
  - increment that port's counter, saturating at 2^CNT_W-1.
- Response drain: rsp_ready high with no new accept clears rsp_valid. rsp_ready high together with an accept in the same cycle replaces the response register (pass-through, no bubble).
- Response stability: while rsp_valid is high and rsp_ready is low, all response outputs hold stable.
- Input sampling: the block reads request payload only in the accept cycle, and requesters may change it afterwards. A valid request must stay asserted until it is accepted.
- Unknown opcodes follow the comparator's default (equality) behaviour and are not flagged.
- Port state machine, per port, derived rather than stored: WAIT (valid && !ready) -> DONE (valid && ready) -> IDLE.
- Block state: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on rsp_ready with no accept.
  - FULL -> FULL on rsp_ready with an accept, or with rsp_ready low.

## Timing
- Reset values: io_rsp_valid_o=0, io_rsp_id_o=0, io_rsp_cmp_o=0, io_rsp_eq_o=0, io_cnt0_o=0, io_cnt1_o=0, last_grant=1.
- The ready outputs are combinational from valid inputs, io_rsp_ready_i and state.
- Reset does not force ready low, but ready is not meaningful while rst_ni is low.
- Latency: a request accepted in cycle N has io_rsp_valid_o high in cycle N+1.
- Throughput: one request per cycle when io_rsp_ready_i is held high.
- Reset asserted mid-operation clears the response register immediately, without waiting for a clock edge. Any pending response is lost, and the counters and the arbiter state return to their reset values.
- No combinational path exists from the request payload to the response outputs. All response outputs come directly from flops.

## Structure
- The shared package `ibex_cmp_pkg` holds:
  - the opcode constants CMP_LT=7'h19, CMP_LTU=7'h1A, CMP_GE=7'h1B, CMP_EQ=7'h1D, CMP_NE=7'h1E;
  - the typedef cmp_req_t {operator, a, b};
  - the typedef cmp_rsp_t {id, cmp, eq}.
- There is one sub-module: the existing comparator block (IbexComparator), instantiated once and fed by the arbitration mux. The subtractor stays inline.
- Target size is about 150–200 lines of RTL.

## Test plan
- Reset and single request:
  - after release, all outputs read 0;
  - stimulus: port0 sends NE with a=5, b=3;
  - required response: ready0=1 in cycle N; in N+1, rsp_valid=1, id=0, cmp=1, eq=0, cnt0=1.
- Tie and round-robin:
  - stimulus: both ports send continuously for 4 cycles, port0 EQ with a=b=7, port1 LTU with a=1, b=2, rsp_ready=1;
  - required response: grants 0,1,0,1; responses (id=0, cmp=1, eq=1) and (id=1, cmp=1, eq=0) alternate; cnt0=2, cnt1=2.
- Backpressure:
  - stimulus: rsp_ready=0 for 3 cycles while port1 keeps requesting;
  - required response: both ready outputs are 0 after the first accept, and the response outputs hold stable; when rsp_ready=1, the next accept lands in the same cycle and rsp_valid stays high with no bubble.
- Wrap-around compare:
  - stimulus: LTU with a=32'h0000_0000, b=32'hFFFF_FFFF;
  - required response: cmp=1, eq=0, with adder_result wrapping to 1.
- Counter saturation:
  - stimulus: CNT_W=2, port0 sends 5 back-to-back requests;
  - required response: cnt0 reaches 3 and stays at 3.
- Reset mid-operation:
  - stimulus: assert rst_ni=0 while rsp_valid=1 and between clock edges;
  - required response: rsp_valid, id, cmp, eq and both counters drop to 0 immediately; the first tie after release goes to port0.
